// File: rtl/shift_pkg.sv
// Shared definitions for the shift_pipe shifter: funct codes, shift modes and the stage-1 payload.
// The optional rotate decode is enabled by the SHIFT_ROTATE_EN macro in shift_pipe and shift_stage.
package shift_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;

    typedef enum logic [1:0] {
        MODE_SRL  = 2'b00,
        MODE_SLL  = 2'b01,
        MODE_SRA  = 2'b10,
        MODE_ROTR = 2'b11
    } shift_mode_e;

    typedef struct packed {
        shift_mode_e     mode;
        logic [4:0]      amt;
        logic [XLEN-1:0] data;
        logic            illegal;
    } s1_payload_t;

    // Unsupported funct codes pass rt_val through untouched and are flagged illegal.
    function automatic s1_payload_t decode_op(input logic [5:0]      funct,
                                              input logic [4:0]      shamt,
                                              input logic [4:0]      rs_amt,
                                              input logic [XLEN-1:0] rt_val);
        s1_payload_t p;
        p.mode    = MODE_SLL;
        p.amt     = 5'd0;
        p.data    = rt_val;
        p.illegal = 1'b0;
        case (funct)
            FUNCT_SLL:  begin p.mode = MODE_SLL; p.amt = shamt;  end
            FUNCT_SRL:  begin p.mode = MODE_SRL; p.amt = shamt;  end
            FUNCT_SRA:  begin p.mode = MODE_SRA; p.amt = shamt;  end
            FUNCT_SLLV: begin p.mode = MODE_SLL; p.amt = rs_amt; end
            FUNCT_SRLV: begin p.mode = MODE_SRL; p.amt = rs_amt; end
            FUNCT_SRAV: begin p.mode = MODE_SRA; p.amt = rs_amt; end
            default:    p.illegal = 1'b1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One conditional power-of-two shift step; the pipeline chains five of these (1, 2, 4, 8, 16).
// Rotate support is compiled in only when SHIFT_ROTATE_EN is defined.
module shift_stage
    import shift_pkg::*;
#(
    parameter int AMOUNT = 1
) (
    input  shift_mode_e     mode,
    input  logic            en,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] dout
);

    always_comb begin
        dout = din;
        if (en) begin
            case (mode)
                MODE_SLL: dout = din << AMOUNT;
                // Sign bit is preserved by every earlier step, so it is still rt_val[31] here.
                MODE_SRA: dout = XLEN'($signed(din) >>> AMOUNT);
`ifdef SHIFT_ROTATE_EN
                MODE_ROTR: dout = (din >> AMOUNT) | (din << (XLEN - AMOUNT));
`endif
                default:  dout = din >> AMOUNT;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined MIPS R-type shifter: decode into stage 1, shifts by 1/2 into stage 2, shifts by 4/8/16
// into an optional output register (OUT_REG). Define SHIFT_ROTATE_EN to decode ROTR/ROTRV.
module shift_pipe
    import shift_pkg::*;
#(
    parameter bit OUT_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      funct,
    input  logic [4:0]      shamt,
    input  logic            rot,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    // Handshake: a transfer happens on the rising edge where valid && ready are both high.
    // Every stage loads when it is empty or its current contents leave on the same edge,
    // so ready depends only on downstream state and never on in_valid.

    s1_payload_t     dec;
    s1_payload_t     s1;
    logic            s1_valid;
    logic            s1_adv;
    logic            s2_valid;
    logic            s2_adv;
    logic            s2_load;
    shift_mode_e     s2_mode;
    logic [2:0]      s2_amt;
    logic [XLEN-1:0] s2_data;
    logic            s2_illegal;
    logic            down_ready;
    logic [XLEN-1:0] sh1, sh2, sh4, sh8, sh16;
    logic            unused_bits;

`ifdef SHIFT_ROTATE_EN
    always_comb begin
        dec = decode_op(funct, shamt, rs_val[4:0], rt_val);
        if (rot && (funct == FUNCT_SRL || funct == FUNCT_SRLV)) begin
            dec.mode = MODE_ROTR;
        end
    end
    assign unused_bits = ^rs_val[XLEN-1:5];
`else
    assign dec         = decode_op(funct, shamt, rs_val[4:0], rt_val);
    assign unused_bits = ^{rot, rs_val[XLEN-1:5]};
`endif

    assign s2_adv   = s2_valid && down_ready;
    assign s2_load  = !s2_valid || s2_adv;
    assign s1_adv   = s1_valid && s2_load;
    assign in_ready = !s1_valid || s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1 <= dec;
            end
        end
    end

    shift_stage #(.AMOUNT(1)) u_sh1 (.mode(s1.mode), .en(s1.amt[0]), .din(s1.data), .dout(sh1));
    shift_stage #(.AMOUNT(2)) u_sh2 (.mode(s1.mode), .en(s1.amt[1]), .din(sh1),     .dout(sh2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_mode    <= MODE_SRL;
            s2_amt     <= '0;
            s2_data    <= '0;
            s2_illegal <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mode    <= s1.mode;
                s2_amt     <= s1.amt[4:2];
                s2_data    <= sh2;
                s2_illegal <= s1.illegal;
            end
        end
    end

    shift_stage #(.AMOUNT(4))  u_sh4  (.mode(s2_mode), .en(s2_amt[0]), .din(s2_data), .dout(sh4));
    shift_stage #(.AMOUNT(8))  u_sh8  (.mode(s2_mode), .en(s2_amt[1]), .din(sh4),     .dout(sh8));
    shift_stage #(.AMOUNT(16)) u_sh16 (.mode(s2_mode), .en(s2_amt[2]), .din(sh8),     .dout(sh16));

    generate
        if (OUT_REG) begin : g_out_reg
            logic            s3_valid;
            logic [XLEN-1:0] s3_result;
            logic            s3_illegal;

            assign down_ready = !s3_valid || out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s3_valid   <= 1'b0;
                    s3_result  <= '0;
                    s3_illegal <= 1'b0;
                end else if (down_ready) begin
                    s3_valid <= s2_valid;
                    if (s2_valid) begin
                        s3_result  <= sh16;
                        s3_illegal <= s2_illegal;
                    end
                end
            end

            assign out_valid = s3_valid;
            assign result    = s3_result;
            assign illegal   = s3_illegal;
        end else begin : g_out_comb
            // Stage-2 data resets to zero, so the combinational result is zero in reset too.
            assign down_ready = out_ready;
            assign out_valid  = s2_valid;
            assign result     = sh16;
            assign illegal    = s2_illegal;
        end
    endgenerate

endmodule
